// File: rtl/mda_pkg.sv
// Shared constants and types for the MDA character-cell pixel path.
package mda_pkg;

  localparam int MDA_CELL_W  = 9;
  localparam int BLINK_CNT_W = 5;

  // Attribute nibble patterns that select the special MDA rendering modes
  localparam logic [2:0] ATTR_INVIS   = 3'b000;
  localparam logic [2:0] ATTR_REVERSE = 3'b111;
  localparam logic [2:0] ATTR_ULINE   = 3'b001;

  localparam int CURSOR_BLINK_BIT = 3;
  localparam int CHAR_BLINK_BIT   = 4;

  localparam logic [2:0] LINE_DRAW_MASK = 3'b110;

  typedef struct packed {
    logic blank;
    logic fg_v;
    logic fg_i;
    logic bg_v;
    logic bg_i;
  } cell_attr_t;

  localparam cell_attr_t CELL_BLANK = '{blank: 1'b1, default: 1'b0};

  // Characters C0h-DFh extend their last font column into the ninth dot
  function automatic logic line_draw_dot(input logic [2:0] code_hi, input logic font_lsb);
    return (code_hi == LINE_DRAW_MASK) ? font_lsb : 1'b0;
  endfunction

endpackage

// File: rtl/mda_blink_counter.sv
// Frame counter driven by vsync rising edges; its upper bits pace cursor and character blink.
module mda_blink_counter
  import mda_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic cursor_blink,
  output logic char_blink
);

  logic                   vsync_q;
  logic [BLINK_CNT_W-1:0] cnt;

  // vsync_q resets high so a vsync already asserted at reset release is not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b1;
      cnt     <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q)
        cnt <= cnt + 5'd1;
    end
  end

  assign cursor_blink = cnt[CURSOR_BLINK_BIT];
  assign char_blink   = cnt[CHAR_BLINK_BIT];

endmodule

// File: rtl/mda_pixel_shifter.sv
// Serialises MDA character cells into 9 video/intensity dots, applying the attribute,
// underline, blink and cursor rules at load time.
module mda_pixel_shifter
  import mda_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       char_load,
  input  logic [7:0] char_code,
  input  logic [7:0] attr,
  input  logic [7:0] font_bits,
  input  logic       display_enable,
  input  logic       cursor,
  input  logic       row_underline,
  input  logic       vsync,
  input  logic       blink_enable,
  output logic       video,
  output logic       intensity
);

  logic cursor_blink;
  logic char_blink;

  mda_blink_counter u_blink (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .cursor_blink (cursor_blink),
    .char_blink   (char_blink)
  );

  logic [MDA_CELL_W-1:0] shift_q;
  logic [MDA_CELL_W-1:0] shift_d;
  cell_attr_t            cell_q;
  cell_attr_t            cell_d;
  logic [2:0]            fg;
  logic [2:0]            bg;
  logic                  pix_v;
  logic                  pix_i;
  logic                  unused_code;

  assign fg          = attr[2:0];
  assign bg          = attr[6:4];
  assign unused_code = ^char_code[4:0];

  // Whole-cell effects (underline, cursor) are folded into an all-ones glyph so that
  // the cell reverts to background once its 9 dots have been shifted out.
  always_comb begin
    cell_d  = CELL_BLANK;
    shift_d = {font_bits, line_draw_dot(char_code[7:5], font_bits[0])};
    if (display_enable) begin
      cell_d.blank = 1'b0;
      if (fg == ATTR_INVIS && bg == ATTR_INVIS) begin
        cell_d.fg_v = 1'b0;
      end else if (fg == ATTR_INVIS && bg == ATTR_REVERSE) begin
        cell_d.bg_v = 1'b1;
        cell_d.bg_i = attr[7] & ~blink_enable;
      end else if (fg == ATTR_ULINE && bg == ATTR_INVIS && row_underline) begin
        cell_d.fg_v = 1'b1;
        cell_d.fg_i = attr[3];
        shift_d     = '1;
      end else begin
        cell_d.fg_v = 1'b1;
        cell_d.fg_i = attr[3];
      end

      if (cursor && cursor_blink) begin
        cell_d.fg_v = 1'b1;
        cell_d.fg_i = attr[3];
        shift_d     = '1;
      end else if (blink_enable && attr[7] && char_blink) begin
        cell_d.fg_v = cell_d.bg_v;
        cell_d.fg_i = cell_d.bg_i;
      end
    end
  end

  always_comb begin
    pix_v = 1'b0;
    pix_i = 1'b0;
    if (!cell_q.blank) begin
      if (shift_q[MDA_CELL_W-1]) begin
        pix_v = cell_q.fg_v;
        pix_i = cell_q.fg_i;
      end else begin
        pix_v = cell_q.bg_v;
        pix_i = cell_q.bg_i;
      end
    end
  end

  // On a load edge the output still renders the old cell's MSB before the new cell lands
  always_ff @(posedge clk) begin
    if (reset) begin
      video     <= 1'b0;
      intensity <= 1'b0;
      shift_q   <= '0;
      cell_q    <= CELL_BLANK;
    end else if (pix_ce) begin
      video     <= pix_v;
      intensity <= pix_i;
      if (char_load) begin
        shift_q <= shift_d;
        cell_q  <= cell_d;
      end else begin
        shift_q <= {shift_q[MDA_CELL_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_mda_pixel_shifter.sv
// Directed self-checking bench for mda_pixel_shifter with hand-computed dot patterns.
module tb_mda_pixel_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic       char_load;
  logic [7:0] char_code;
  logic [7:0] attr;
  logic [7:0] font_bits;
  logic       display_enable;
  logic       cursor;
  logic       row_underline;
  logic       vsync;
  logic       blink_enable;
  logic       video;
  logic       intensity;

  int checks = 0;
  int errors = 0;

  mda_pixel_shifter dut (
    .clk            (clk),
    .reset          (reset),
    .pix_ce         (pix_ce),
    .char_load      (char_load),
    .char_code      (char_code),
    .attr           (attr),
    .font_bits      (font_bits),
    .display_enable (display_enable),
    .cursor         (cursor),
    .row_underline  (row_underline),
    .vsync          (vsync),
    .blink_enable   (blink_enable),
    .video          (video),
    .intensity      (intensity)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic ev, input logic ei);
    checks++;
    assert (video === ev) else begin
      errors++;
      $error("[TB] FAIL %s video: observed %b expected %b", tag, video, ev);
    end
    checks++;
    assert (intensity === ei) else begin
      errors++;
      $error("[TB] FAIL %s intensity: observed %b expected %b", tag, intensity, ei);
    end
  endtask

  // Presents a cell on the load edge; returns 1 time unit after that edge
  task automatic apply_stimulus(input logic [7:0] code, input logic [7:0] a, input logic [7:0] font,
                                input logic de, input logic cur, input logic ul, input logic be);
    char_code      = code;
    attr           = a;
    font_bits      = font;
    display_enable = de;
    cursor         = cur;
    row_underline  = ul;
    blink_enable   = be;
    pix_ce         = 1'b1;
    char_load      = 1'b1;
    @(posedge clk);
    #1;
    char_load = 1'b0;
  endtask

  task automatic check_dots(input string tag, input int first, input int last,
                            input logic [8:0] ev, input logic [8:0] ei);
    for (int k = first; k <= last; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("%s dot%0d", tag, k), ev[8-k], ei[8-k]);
    end
  endtask

  task automatic vsync_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      vsync = 1'b1;
      @(posedge clk);
      #1;
      vsync = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset          = 1'b1;
    pix_ce         = 1'b1;
    char_load      = 1'b0;
    char_code      = 8'h00;
    attr           = 8'h00;
    font_bits      = 8'h00;
    display_enable = 1'b0;
    cursor         = 1'b0;
    row_underline  = 1'b0;
    vsync          = 1'b0;
    blink_enable   = 1'b0;

    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("reset cycle%0d", c), 1'b0, 1'b0);
    end
    reset = 1'b0;

    apply_stimulus(8'h41, 8'h07, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("normal", 0, 8, 9'b101001010, 9'b000000000);
    apply_stimulus(8'h41, 8'h0F, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("bright", 0, 8, 9'b101001010, 9'b101001010);

    apply_stimulus(8'hC4, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("linedraw", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'h41, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("no dot8", 0, 8, 9'b111111110, 9'b000000000);

    apply_stimulus(8'h41, 8'h70, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("reverse", 0, 8, 9'b000011111, 9'b000000000);
    apply_stimulus(8'h41, 8'hF0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("reverse bright", 0, 8, 9'b000011111, 9'b000011111);
    check_dots("idle background", 0, 1, 9'b110000000, 9'b110000000);

    apply_stimulus(8'h41, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("invisible", 0, 8, 9'b000000000, 9'b000000000);
    apply_stimulus(8'hC4, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dots("blank", 0, 8, 9'b000000000, 9'b000000000);

    apply_stimulus(8'h41, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check_dots("underline", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'h41, 8'h09, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check_dots("underline bright", 0, 8, 9'b111111111, 9'b111111111);
    apply_stimulus(8'h41, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("not underline row", 0, 8, 9'b000000000, 9'b000000000);

    // Early reload: the load edge shows old dot3, then the new cell starts from dot0
    apply_stimulus(8'h41, 8'h07, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("early old", 0, 2, 9'b101000000, 9'b000000000);
    apply_stimulus(8'h41, 8'h07, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("early load edge", 1'b0, 1'b0);
    check_dots("early new", 0, 8, 9'b111100000, 9'b000000000);

    // Stalled dot clock: output holds and char_load without pix_ce is ignored
    apply_stimulus(8'h41, 8'h07, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("stall pre", 0, 2, 9'b101000000, 9'b000000000);
    pix_ce    = 1'b0;
    char_load = 1'b1;
    attr      = 8'h00;
    font_bits = 8'h00;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("stall hold%0d", c), 1'b1, 1'b0);
    end
    char_load = 1'b0;
    pix_ce    = 1'b1;
    check_dots("stall post", 3, 8, 9'b101001010, 9'b000000000);

    apply_stimulus(8'h41, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("mid reset pre", 0, 1, 9'b110000000, 9'b000000000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("mid reset", 1'b0, 1'b0);
    reset = 1'b0;
    check_dots("after reset", 0, 2, 9'b000000000, 9'b000000000);

    // Blink counter at 8: cursor phase on, character blink off
    vsync_pulses(8);
    apply_stimulus(8'h41, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dots("cursor", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'h41, 8'h0F, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dots("cursor bright", 0, 8, 9'b111111111, 9'b111111111);
    apply_stimulus(8'hC4, 8'h87, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check_dots("blink phase off", 0, 8, 9'b111111111, 9'b000000000);

    // Counter at 24: both blink phases on
    vsync_pulses(16);
    apply_stimulus(8'hC4, 8'h87, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check_dots("char blink", 0, 8, 9'b000000000, 9'b000000000);
    apply_stimulus(8'hC4, 8'h87, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dots("blink disabled", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'hC4, 8'h87, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    check_dots("cursor over blink", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'h41, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check_dots("cursor blank cell", 0, 8, 9'b000000000, 9'b000000000);

    // Counter wraps 31 -> 0: both phases off again
    vsync_pulses(8);
    apply_stimulus(8'hC4, 8'h87, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check_dots("wrap blink", 0, 8, 9'b111111111, 9'b000000000);
    apply_stimulus(8'h41, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check_dots("wrap cursor", 0, 8, 9'b000000000, 9'b000000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
